// File: rtl/sdram_arb_pkg.sv
// -----------------------------------------------------------------------------
// sdram_arb_pkg
//   Shared definitions for the two-port SDRAM host arbiter.
//   - FSM state encoding (legacy-compatible localparam constants)
//   - port index type and port constants
//   - helper function returning the opposite port index
// -----------------------------------------------------------------------------
package sdram_arb_pkg;

    // Arbiter FSM state encoding
    localparam logic [1:0] ARB_IDLE   = 2'b00;
    localparam logic [1:0] ARB_ISSUE  = 2'b01;
    localparam logic [1:0] ARB_RDWAIT = 2'b10;

    // Index of a host port (two ports: 0 and 1)
    typedef logic port_idx_t;

    localparam port_idx_t PORT0 = 1'b0;
    localparam port_idx_t PORT1 = 1'b1;

    // The port that is not p; used for round-robin tie breaking
    function automatic port_idx_t other_port(input port_idx_t p);
        return port_idx_t'(~p);
    endfunction

endpackage

// File: rtl/sdram_arb_rr.sv
// -----------------------------------------------------------------------------
// sdram_arb_rr
//   Two-way round-robin selector. Purely combinational.
//   Ports:
//     req[1:0]    in  - request vector, bit N = port N requesting
//     last_grant  in  - port granted most recently
//     grant       out - selected port (meaningful only when valid=1)
//     valid       out - at least one request present
//   On a tie the port that did not win last time is selected; a single
//   requester is always selected.
// -----------------------------------------------------------------------------
module sdram_arb_rr
    import sdram_arb_pkg::*;
(
    input  logic [1:0] req,
    input  port_idx_t  last_grant,
    output port_idx_t  grant,
    output logic       valid
);

    // Select the next port from the request vector and the previous winner
    always_comb begin
        grant = PORT0;
        valid = |req;
        case (req)
            2'b01:   grant = PORT0;
            2'b10:   grant = PORT1;
            2'b11:   grant = other_port(last_grant);
            default: grant = PORT0;
        endcase
    end

endmodule

// File: rtl/sdram_arbiter.sv
// -----------------------------------------------------------------------------
// sdram_arbiter
//   Arbitrates two byte-wide host ports onto a single SDRAM controller
//   command interface, one transaction at a time, round-robin on contention.
//
//   Parameters:
//     HADDR_WIDTH     - host address width (bank+row+col), default 25
//     TIMEOUT_CYCLES  - read-return watchdog limit in clk cycles, default 64
//
//   Optional feature macro:
//     SDRAM_ARB_TIMEOUT_EN - when defined, a watchdog ends a read that has
//                            waited TIMEOUT_CYCLES cycles in ARB_RDWAIT with an
//                            error pulse (pN_rvalid=1, pN_rerr=1, pN_rdata=0).
//                            When undefined the FSM waits forever and pN_rerr
//                            is tied low.
//
//   Ports:
//     clk, rst_n                 - clock, asynchronous active-low reset
//     pN_req/we/addr/wdata       - host request (held until pN_ack)
//     pN_ack                     - request accepted (same cycle as mem_ack)
//     pN_rdata/rvalid/rerr       - read return to the owning port
//     mem_wr_addr/data/enable    - controller write command
//     mem_rd_addr/enable         - controller read command
//     mem_rd_data/rd_ready       - controller read return
//     mem_ack                    - controller accepted the current command
// -----------------------------------------------------------------------------
module sdram_arbiter
    import sdram_arb_pkg::*;
#(
    parameter int HADDR_WIDTH    = 25,
    parameter int TIMEOUT_CYCLES = 64
)
(
    input  logic                   clk,
    input  logic                   rst_n,

    input  logic                   p0_req,
    input  logic                   p0_we,
    input  logic [HADDR_WIDTH-1:0] p0_addr,
    input  logic [7:0]             p0_wdata,
    output logic                   p0_ack,
    output logic [7:0]             p0_rdata,
    output logic                   p0_rvalid,
    output logic                   p0_rerr,

    input  logic                   p1_req,
    input  logic                   p1_we,
    input  logic [HADDR_WIDTH-1:0] p1_addr,
    input  logic [7:0]             p1_wdata,
    output logic                   p1_ack,
    output logic [7:0]             p1_rdata,
    output logic                   p1_rvalid,
    output logic                   p1_rerr,

    output logic [HADDR_WIDTH-1:0] mem_wr_addr,
    output logic [7:0]             mem_wr_data,
    output logic                   mem_wr_enable,
    output logic [HADDR_WIDTH-1:0] mem_rd_addr,
    output logic                   mem_rd_enable,
    input  logic [7:0]             mem_rd_data,
    input  logic                   mem_rd_ready,
    input  logic                   mem_ack
);

    logic [1:0]             state_r;
    logic [1:0]             state_nxt_s;
    port_idx_t              owner_r;
    port_idx_t              last_grant_r;
    logic                   we_r;
    logic [HADDR_WIDTH-1:0] mem_addr_r;
    logic [7:0]             mem_wr_data_r;
    logic                   mem_wr_enable_r;
    logic                   mem_rd_enable_r;
    logic [7:0]             p0_rdata_r;
    logic [7:0]             p1_rdata_r;
    logic                   p0_rvalid_r;
    logic                   p1_rvalid_r;

    port_idx_t              rr_grant_s;
    logic                   rr_valid_s;
    logic                   grant_fire_s;
    logic                   ack_fire_s;
    logic                   rd_done_s;
    logic                   timeout_s;

    logic                   sel_we_s;
    logic [HADDR_WIDTH-1:0] sel_addr_s;
    logic [7:0]             sel_wdata_s;

    sdram_arb_rr u_rr (
        .req        ({p1_req, p0_req}),
        .last_grant (last_grant_r),
        .grant      (rr_grant_s),
        .valid      (rr_valid_s)
    );

    // Only the idle state may grant, so an outstanding read blocks new grants
    assign grant_fire_s = (state_r == ARB_IDLE)   && rr_valid_s;
    // mem_ack and mem_rd_ready are only meaningful in their own states
    assign ack_fire_s   = (state_r == ARB_ISSUE)  && mem_ack;
    assign rd_done_s    = (state_r == ARB_RDWAIT) && mem_rd_ready;

`ifdef SDRAM_ARB_TIMEOUT_EN
    localparam int WDOG_W = $clog2(TIMEOUT_CYCLES) + 1;

    logic [WDOG_W-1:0] wdog_r;
    logic              p0_rerr_r;
    logic              p1_rerr_r;

    // Fires on the TIMEOUT_CYCLES-th consecutive waiting cycle; a late
    // mem_rd_ready in that same cycle still wins over the timeout
    assign timeout_s = (state_r == ARB_RDWAIT) && !mem_rd_ready &&
                       (wdog_r == WDOG_W'(TIMEOUT_CYCLES - 1));

    // Watchdog: counts waiting cycles, restarts whenever the wait is not active
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wdog_r <= '0;
        end else if (state_r != ARB_RDWAIT) begin
            wdog_r <= '0;
        end else if (mem_rd_ready || timeout_s) begin
            wdog_r <= '0;
        end else begin
            wdog_r <= wdog_r + WDOG_W'(1);
        end
    end

    // Read-error flags, one-cycle pulses aligned with the owner's rvalid
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            p0_rerr_r <= 1'b0;
            p1_rerr_r <= 1'b0;
        end else begin
            p0_rerr_r <= timeout_s && (owner_r == PORT0);
            p1_rerr_r <= timeout_s && (owner_r == PORT1);
        end
    end

    assign p0_rerr = p0_rerr_r;
    assign p1_rerr = p1_rerr_r;
`else
    assign timeout_s = 1'b0;
    assign p0_rerr   = 1'b0;
    assign p1_rerr   = 1'b0;
`endif

    // Fields of the port chosen by the round-robin selector
    always_comb begin
        if (rr_grant_s == PORT1) begin
            sel_we_s    = p1_we;
            sel_addr_s  = p1_addr;
            sel_wdata_s = p1_wdata;
        end else begin
            sel_we_s    = p0_we;
            sel_addr_s  = p0_addr;
            sel_wdata_s = p0_wdata;
        end
    end

    // Next-state logic of the arbiter FSM
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ARB_IDLE: begin
                if (rr_valid_s) begin
                    state_nxt_s = ARB_ISSUE;
                end else begin
                    state_nxt_s = ARB_IDLE;
                end
            end
            ARB_ISSUE: begin
                if (mem_ack) begin
                    state_nxt_s = we_r ? ARB_IDLE : ARB_RDWAIT;
                end else begin
                    state_nxt_s = ARB_ISSUE;
                end
            end
            ARB_RDWAIT: begin
                if (mem_rd_ready || timeout_s) begin
                    state_nxt_s = ARB_IDLE;
                end else begin
                    state_nxt_s = ARB_RDWAIT;
                end
            end
            default: begin
                state_nxt_s = ARB_IDLE;
            end
        endcase
    end

    // FSM state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ARB_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Grant bookkeeping and latch of the winning request's fields
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            owner_r       <= PORT0;
            last_grant_r  <= PORT1;    // so port 0 wins the first tie
            we_r          <= 1'b0;
            mem_addr_r    <= '0;
            mem_wr_data_r <= 8'h00;
        end else if (grant_fire_s) begin
            owner_r       <= rr_grant_s;
            last_grant_r  <= rr_grant_s;
            we_r          <= sel_we_s;
            mem_addr_r    <= sel_addr_s;
            mem_wr_data_r <= sel_wdata_s;
        end else begin
            owner_r       <= owner_r;
            last_grant_r  <= last_grant_r;
            we_r          <= we_r;
            mem_addr_r    <= mem_addr_r;
            mem_wr_data_r <= mem_wr_data_r;
        end
    end

    // Command enables: raised on grant, held through any stall, dropped after mem_ack
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_wr_enable_r <= 1'b0;
            mem_rd_enable_r <= 1'b0;
        end else if (grant_fire_s) begin
            mem_wr_enable_r <= sel_we_s;
            mem_rd_enable_r <= !sel_we_s;
        end else if (ack_fire_s) begin
            mem_wr_enable_r <= 1'b0;
            mem_rd_enable_r <= 1'b0;
        end else begin
            mem_wr_enable_r <= mem_wr_enable_r;
            mem_rd_enable_r <= mem_rd_enable_r;
        end
    end

    // Read return: capture data (or zero on timeout) for the owner and pulse its rvalid
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            p0_rdata_r  <= 8'h00;
            p1_rdata_r  <= 8'h00;
            p0_rvalid_r <= 1'b0;
            p1_rvalid_r <= 1'b0;
        end else begin
            p0_rvalid_r <= 1'b0;
            p1_rvalid_r <= 1'b0;
            if (rd_done_s || timeout_s) begin
                if (owner_r == PORT0) begin
                    p0_rdata_r  <= rd_done_s ? mem_rd_data : 8'h00;
                    p0_rvalid_r <= 1'b1;
                end else begin
                    p1_rdata_r  <= rd_done_s ? mem_rd_data : 8'h00;
                    p1_rvalid_r <= 1'b1;
                end
            end else begin
                p0_rdata_r <= p0_rdata_r;
                p1_rdata_r <= p1_rdata_r;
            end
        end
    end

    // Acceptance is combinational so the requester can move on the next cycle
    assign p0_ack = mem_ack && (state_r == ARB_ISSUE) && (owner_r == PORT0);
    assign p1_ack = mem_ack && (state_r == ARB_ISSUE) && (owner_r == PORT1);

    assign p0_rdata  = p0_rdata_r;
    assign p1_rdata  = p1_rdata_r;
    assign p0_rvalid = p0_rvalid_r;
    assign p1_rvalid = p1_rvalid_r;

    // Both command addresses carry the same latched address
    assign mem_wr_addr   = mem_addr_r;
    assign mem_rd_addr   = mem_addr_r;
    assign mem_wr_data   = mem_wr_data_r;
    assign mem_wr_enable = mem_wr_enable_r;
    assign mem_rd_enable = mem_rd_enable_r;

endmodule

// File: tb/tb_sdram_arbiter.sv
// -----------------------------------------------------------------------------
// tb_sdram_arbiter
//   Self-checking bench for sdram_arbiter. A transaction-level model tracks
//   the single in-flight transaction and the round-robin winner; a negedge
//   process compares every DUT output against it each cycle. Directed
//   scenarios add hand-computed literal expectations.
// -----------------------------------------------------------------------------
module tb_sdram_arbiter;

    localparam int HW = 25;
    localparam int TO = 8;
`ifdef SDRAM_ARB_TIMEOUT_EN
    localparam bit TO_EN = 1'b1;
`else
    localparam bit TO_EN = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst_n;
    logic          p0_req, p0_we, p1_req, p1_we;
    logic [HW-1:0] p0_addr, p1_addr;
    logic [7:0]    p0_wdata, p1_wdata;
    logic          p0_ack, p0_rvalid, p0_rerr, p1_ack, p1_rvalid, p1_rerr;
    logic [7:0]    p0_rdata, p1_rdata;
    logic [HW-1:0] mem_wr_addr, mem_rd_addr;
    logic [7:0]    mem_wr_data, mem_rd_data;
    logic          mem_wr_enable, mem_rd_enable, mem_rd_ready, mem_ack;

    always #5 clk = ~clk;

    sdram_arbiter #(.HADDR_WIDTH(HW), .TIMEOUT_CYCLES(TO)) dut (
        .clk(clk), .rst_n(rst_n),
        .p0_req(p0_req), .p0_we(p0_we), .p0_addr(p0_addr), .p0_wdata(p0_wdata),
        .p0_ack(p0_ack), .p0_rdata(p0_rdata), .p0_rvalid(p0_rvalid), .p0_rerr(p0_rerr),
        .p1_req(p1_req), .p1_we(p1_we), .p1_addr(p1_addr), .p1_wdata(p1_wdata),
        .p1_ack(p1_ack), .p1_rdata(p1_rdata), .p1_rvalid(p1_rvalid), .p1_rerr(p1_rerr),
        .mem_wr_addr(mem_wr_addr), .mem_wr_data(mem_wr_data), .mem_wr_enable(mem_wr_enable),
        .mem_rd_addr(mem_rd_addr), .mem_rd_enable(mem_rd_enable),
        .mem_rd_data(mem_rd_data), .mem_rd_ready(mem_rd_ready), .mem_ack(mem_ack)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- transaction-level model ----------------
    // busy: a transaction owns the controller; cmd_pending: command not yet
    // accepted; waiting: accepted read whose data has not come back.
    bit          busy, cmd_pending, waiting;
    int          owner, last_winner, wait_cycles;
    bit          t_write;
    logic [HW-1:0] t_addr;
    logic [7:0]  t_data;
    logic [7:0]  rd_hold [2];
    bit          rv_pulse [2];
    bit          err_pulse;
    int          ack_cnt [2];

    task automatic model_reset();
        busy = 0; cmd_pending = 0; waiting = 0;
        owner = 0; last_winner = 1; wait_cycles = 0;
        t_write = 0; t_addr = '0; t_data = 8'h00;
        rd_hold[0] = 8'h00; rd_hold[1] = 8'h00;
        rv_pulse[0] = 0; rv_pulse[1] = 0; err_pulse = 0;
    endtask

    task automatic model_compare();
        bit a0, a1;
        a0 = mem_ack && cmd_pending && owner == 0;
        a1 = mem_ack && cmd_pending && owner == 1;
        chk("p0_ack", 32'(p0_ack), 32'(a0));
        chk("p1_ack", 32'(p1_ack), 32'(a1));
        chk("mem_wr_enable", 32'(mem_wr_enable), 32'(cmd_pending && t_write));
        chk("mem_rd_enable", 32'(mem_rd_enable), 32'(cmd_pending && !t_write));
        chk("mem_wr_addr", 32'(mem_wr_addr), 32'(t_addr));
        chk("mem_rd_addr", 32'(mem_rd_addr), 32'(t_addr));
        chk("mem_wr_data", 32'(mem_wr_data), 32'(t_data));
        chk("p0_rvalid", 32'(p0_rvalid), 32'(rv_pulse[0]));
        chk("p1_rvalid", 32'(p1_rvalid), 32'(rv_pulse[1]));
        chk("p0_rdata", 32'(p0_rdata), 32'(rd_hold[0]));
        chk("p1_rdata", 32'(p1_rdata), 32'(rd_hold[1]));
        chk("p0_rerr", 32'(p0_rerr), 32'(err_pulse && rv_pulse[0]));
        chk("p1_rerr", 32'(p1_rerr), 32'(err_pulse && rv_pulse[1]));
        if (p0_ack) ack_cnt[0]++;
        if (p1_ack) ack_cnt[1]++;
    endtask

    // Advance the model by one clock using this cycle's inputs
    task automatic model_step();
        int win;
        rv_pulse[0] = 0; rv_pulse[1] = 0; err_pulse = 0;
        if (!busy) begin
            if (p0_req || p1_req) begin
                if (p0_req && p1_req) win = 1 - last_winner;
                else                  win = p1_req ? 1 : 0;
                owner = win; last_winner = win;
                t_write = win ? p1_we : p0_we;
                t_addr  = win ? p1_addr : p0_addr;
                t_data  = win ? p1_wdata : p0_wdata;
                busy = 1; cmd_pending = 1;
            end
        end else if (cmd_pending) begin
            if (mem_ack) begin
                cmd_pending = 0;
                waiting = !t_write;
                busy = !t_write;
                wait_cycles = 0;
            end
        end else if (waiting) begin
            if (mem_rd_ready) begin
                rd_hold[owner] = mem_rd_data; rv_pulse[owner] = 1;
                waiting = 0; busy = 0;
            end else if (TO_EN) begin
                wait_cycles++;
                if (wait_cycles == TO) begin
                    rd_hold[owner] = 8'h00; rv_pulse[owner] = 1; err_pulse = 1;
                    waiting = 0; busy = 0;
                end
            end
        end
    endtask

    // Compare process: check every output each cycle, away from the active edge
    always @(negedge clk) begin
        if (!rst_n) model_reset();
        model_compare();
        if (rst_n) model_step();
    end

    // ---------------- stimulus ----------------
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        p0_req = 0; p0_we = 0; p0_addr = '0; p0_wdata = 8'h00;
        p1_req = 0; p1_we = 0; p1_addr = '0; p1_wdata = 8'h00;
        mem_ack = 0; mem_rd_ready = 0; mem_rd_data = 8'h00;
    endtask

    task automatic apply_reset();
        rst_n = 0;
        idle_inputs();
        repeat (2) cyc();
        rst_n = 1;
    endtask

    // Bounded wait for a command enable; an expired bound is a failed check
    task automatic wait_en();
        int n;
        n = 0;
        while (!(mem_wr_enable || mem_rd_enable) && n < 20) begin
            cyc();
            n++;
        end
        chk("enable seen", 32'(mem_wr_enable || mem_rd_enable), 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL global timeout");
        $fatal(1, "global timeout");
    end

    initial begin
        int base, stall, acks, blocked, seen, n;
        int seq [4];
        rst_n = 0;
        idle_inputs();
        repeat (3) cyc();
        rst_n = 1;

        // Reset state
        chk("rst mem_wr_enable", 32'(mem_wr_enable), 32'd0);
        chk("rst mem_rd_enable", 32'(mem_rd_enable), 32'd0);
        chk("rst p0_rdata", 32'(p0_rdata), 32'd0);
        chk("rst mem_wr_addr", 32'(mem_wr_addr), 32'd0);

        // Stray controller handshakes in idle are ignored
        mem_ack = 1; mem_rd_ready = 1; mem_rd_data = 8'hFF;
        cyc();
        mem_ack = 0; mem_rd_ready = 0;
        cyc();
        chk("idle stray rvalid", 32'(p0_rvalid | p1_rvalid), 32'd0);
        chk("idle stray rdata", 32'(p0_rdata), 32'd0);

        // Single read on port 0
        base = ack_cnt[0];
        p0_req = 1; p0_we = 0; p0_addr = 25'h0123456;
        cyc();
        chk("rd enable", 32'(mem_rd_enable), 32'd1);
        chk("rd addr", 32'(mem_rd_addr), 32'h0123456);
        repeat (3) cyc();
        mem_ack = 1;
        #1;
        chk("rd p0_ack", 32'(p0_ack), 32'd1);
        cyc();
        mem_ack = 0; p0_req = 0;
        chk("rd enable dropped", 32'(mem_rd_enable), 32'd0);
        repeat (3) cyc();
        mem_rd_ready = 1; mem_rd_data = 8'hA5;
        cyc();
        mem_rd_ready = 0;
        chk("rd p0_rvalid", 32'(p0_rvalid), 32'd1);
        chk("rd p0_rdata", 32'(p0_rdata), 32'hA5);
        chk("rd p1_rvalid", 32'(p1_rvalid), 32'd0);
        chk("rd ack count", 32'(ack_cnt[0] - base), 32'd1);
        cyc();
        chk("rd rvalid pulse", 32'(p0_rvalid), 32'd0);
        chk("rd rdata held", 32'(p0_rdata), 32'hA5);

        // Contention: both ports write continuously
        apply_reset();
        p0_req = 1; p0_we = 1; p0_addr = 25'h0000100; p0_wdata = 8'h10;
        p1_req = 1; p1_we = 1; p1_addr = 25'h0000200; p1_wdata = 8'h20;
        for (int k = 0; k < 4; k++) begin
            wait_en();
            mem_ack = 1;
            #1;
            seq[k] = p1_ack ? 1 : 0;
            chk("contention single ack", 32'(p0_ack) + 32'(p1_ack), 32'd1);
            cyc();
            mem_ack = 0;
            if (seq[k] == 1) begin p1_addr = p1_addr + 1; p1_wdata = p1_wdata + 8'h01; end
            else             begin p0_addr = p0_addr + 1; p0_wdata = p0_wdata + 8'h01; end
        end
        p0_req = 0; p1_req = 0;
        chk("grant 0", 32'(seq[0]), 32'd0);
        chk("grant 1", 32'(seq[1]), 32'd1);
        chk("grant 2", 32'(seq[2]), 32'd0);
        chk("grant 3", 32'(seq[3]), 32'd1);
        cyc();

        // Refresh stall: ack withheld 20 cycles
        p1_req = 1; p1_we = 1; p1_addr = 25'h1ABCDEF; p1_wdata = 8'h5A;
        wait_en();
        stall = 0; acks = 0;
        repeat (20) begin
            if (mem_wr_enable) stall++;
            if (p0_ack || p1_ack) acks++;
            cyc();
        end
        chk("stall enable cycles", 32'(stall), 32'd20);
        chk("stall acks", 32'(acks), 32'd0);
        mem_ack = 1;
        #1;
        chk("stall p1_ack", 32'(p1_ack), 32'd1);
        chk("stall wr_data", 32'(mem_wr_data), 32'h5A);
        chk("stall wr_addr", 32'(mem_wr_addr), 32'h1ABCDEF);
        cyc();
        mem_ack = 0; p1_req = 0;
        cyc();

        // Read on p1 pending while p0 wants to write
        p1_req = 1; p1_we = 0; p1_addr = 25'h0000ABC;
        wait_en();
        mem_ack = 1;
        cyc();
        mem_ack = 0; p1_req = 0;
        p0_req = 1; p0_we = 1; p0_addr = 25'h0000777; p0_wdata = 8'h77;
        blocked = 0;
        repeat (5) begin
            if (mem_wr_enable || mem_rd_enable) blocked++;
            cyc();
        end
        chk("rdwait no grant", 32'(blocked), 32'd0);
        mem_rd_ready = 1; mem_rd_data = 8'h3C;
        cyc();
        mem_rd_ready = 0;
        chk("p1 rvalid", 32'(p1_rvalid), 32'd1);
        chk("p1 rdata", 32'(p1_rdata), 32'h3C);
        chk("p0 rvalid idle", 32'(p0_rvalid), 32'd0);
        chk("no grant in rvalid cycle", 32'(mem_wr_enable), 32'd0);
        cyc();
        chk("p0 granted after rvalid", 32'(mem_wr_enable), 32'd1);
        chk("p0 write addr", 32'(mem_wr_addr), 32'h0000777);
        mem_ack = 1;
        cyc();
        mem_ack = 0; p0_req = 0;
        cyc();

        // Read with no data return: watchdog or indefinite wait
        p0_req = 1; p0_we = 0; p0_addr = 25'h0000055;
        wait_en();
        mem_ack = 1;
        cyc();
        mem_ack = 0; p0_req = 0;
        p1_req = 1; p1_we = 1; p1_addr = 25'h0000066; p1_wdata = 8'h66;
        if (TO_EN) begin
            n = 0;
            while (!p0_rvalid && n < 40) begin
                cyc();
                n++;
            end
            chk("timeout latency", 32'(n), 32'(TO));
            chk("timeout rvalid", 32'(p0_rvalid), 32'd1);
            chk("timeout rerr", 32'(p0_rerr), 32'd1);
            chk("timeout rdata", 32'(p0_rdata), 32'd0);
        end else begin
            seen = 0; blocked = 0;
            repeat (100) begin
                if (p0_rvalid || p0_rerr) seen++;
                if (mem_wr_enable || mem_rd_enable) blocked++;
                cyc();
            end
            chk("no timeout rvalid", 32'(seen), 32'd0);
            chk("no grant while waiting", 32'(blocked), 32'd0);
        end
        // Reset abandons anything still in flight; no rvalid afterwards
        apply_reset();
        seen = 0;
        repeat (5) begin
            if (p0_rvalid || p1_rvalid) seen++;
            cyc();
        end
        chk("abandon no rvalid", 32'(seen), 32'd0);

        // Reset asserted while a port-0 command is being issued
        p0_req = 1; p0_we = 0; p0_addr = 25'h0000123;
        wait_en();
        chk("issue rd enable", 32'(mem_rd_enable), 32'd1);
        #3;
        rst_n = 0;
        #1;
        chk("async drop rd_en", 32'(mem_rd_enable), 32'd0);
        chk("async drop wr_en", 32'(mem_wr_enable), 32'd0);
        p0_req = 1; p0_we = 1; p0_addr = 25'h0000AAA; p0_wdata = 8'hAA;
        p1_req = 1; p1_we = 1; p1_addr = 25'h0000BBB; p1_wdata = 8'hBB;
        cyc();
        cyc();
        rst_n = 1;
        wait_en();
        mem_ack = 1;
        #1;
        chk("post-reset p0 first", 32'(p0_ack), 32'd1);
        chk("post-reset p1 waits", 32'(p1_ack), 32'd0);
        chk("post-reset addr", 32'(mem_wr_addr), 32'h0000AAA);
        cyc();
        mem_ack = 0; p0_req = 0;
        wait_en();
        mem_ack = 1;
        #1;
        chk("then p1", 32'(p1_ack), 32'd1);
        cyc();
        mem_ack = 0; p1_req = 0;
        repeat (3) cyc();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
